divclk_serializer: RTL

Downstream consumer of clock_divider. Uses its preRise/preFall strobes to shift a parallel word out on sdo and capture sdi, full duplex, in a SPI-mode-0 style.
- sdo changes on divClk falling edges.
- sdi is sampled on divClk rising edges.
- Provides a chip-select output and a gate so divClk reaches the pin only during a transfer.
- Sits between the system-side valid/ready producer and the pad logic.

---
 rtl/divclk_serializer_pkg.sv | 20 ++
 rtl/divclk_serializer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/divclk_serializer_pkg.sv
// Shared types and defaults for the divClk-strobed SPI-mode-0 style serializer.
package divclk_serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RISE,
    WAIT_FALL,
    WAIT_LAST,
    GAP
  } state_e;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_CS_GAP = 2;

  // Bit counter width; never below one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/divclk_serializer.sv
// Full-duplex serializer driven by clock_divider preRise/preFall strobes.
// Define DIVCLK_SERIALIZER_LSB_FIRST_EN for LSB-first shifting in both directions.
module divclk_serializer
  import divclk_serializer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CS_GAP = DEF_CS_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preRise,
  input  logic             preFall,
  input  logic [WIDTH-1:0] txData,
  input  logic             txValid,
  output logic             txReady,
  input  logic             sdi,
  output logic             sdo,
  output logic             csN,
  output logic             sclkGate,
  output logic [WIDTH-1:0] rxData,
  output logic             rxValid,
  output logic             busy
);

  // Handshake: a word moves on any posedge clk where txValid and txReady are
  // both high; txReady is only ever high in IDLE, so txData is sampled once.

  localparam int CW = cnt_w(WIDTH);
  localparam int GW = 4;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] rx_data_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [GW-1:0]    gap_q;
  logic             tx_ready_q;
  logic             sdo_q;
  logic             cs_n_q;
  logic             gate_q;
  logic             rx_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] rx_shift_d;
  logic             load_bit;
  logic             next_bit;

  always_comb begin
`ifdef DIVCLK_SERIALIZER_LSB_FIRST_EN
    load_bit   = txData[0];
    shift_d    = shift_q >> 1;
    next_bit   = shift_q[1];
    rx_shift_d = {sdi, rx_shift_q[WIDTH-1:1]};
`else
    load_bit   = txData[WIDTH-1];
    shift_d    = shift_q << 1;
    next_bit   = shift_q[WIDTH-2];
    rx_shift_d = {rx_shift_q[WIDTH-2:0], sdi};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      gap_q      <= '0;
      tx_ready_q <= 1'b1;
      sdo_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      gate_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (txValid && tx_ready_q) begin
            shift_q    <= txData;
            bit_cnt_q  <= CW'(WIDTH - 1);
            sdo_q      <= load_bit;
            cs_n_q     <= 1'b0;
            gate_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (preRise) begin
            rx_shift_q <= rx_shift_d;
            state_q    <= (bit_cnt_q == '0) ? WAIT_LAST : WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (preFall) begin
            shift_q   <= shift_d;
            sdo_q     <= next_bit;
            bit_cnt_q <= bit_cnt_q - 1'b1;
            state_q   <= WAIT_RISE;
          end
        end
        WAIT_LAST: begin
          // The final falling edge closes the frame and publishes the word.
          if (preFall) begin
            cs_n_q     <= 1'b1;
            gate_q     <= 1'b0;
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            if (CS_GAP == 0) begin
              state_q    <= IDLE;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              gap_q   <= GW'(CS_GAP);
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txReady  = tx_ready_q;
  assign sdo      = sdo_q;
  assign csN      = cs_n_q;
  assign sclkGate = gate_q;
  assign rxData   = rx_data_q;
  assign rxValid  = rx_valid_q;
  assign busy     = busy_q;

endmodule
